rns_scaler_iter: RTL

//  Multi-pass sequential scaler for the RNS moduli set {m1=2^(N+1)-1, m2=2^N, m3=2^N-1}.

---
 rtl/rns_scaler_iter.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/rns_scaler_iter.sv
// rns_scaler_iter: multi-pass scaler by 2^N over the RNS set {2^(N+1)-1, 2^N, 2^N-1}.
// Each pass takes two cycles (modular subtract/rotate, then CRT rebuild of the
// 2^N channel); operands are accepted only in IDLE and held in DONE until taken.
module rns_scaler_iter #(
  parameter int N          = 5,
  parameter int MAX_PASSES = 3,
  parameter int PASS_W     = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [N:0]        in_r1,
  input  logic [N-1:0]      in_r2,
  input  logic [N-1:0]      in_r3,
  input  logic [PASS_W-1:0] in_passes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [N:0]        out_r1,
  output logic [N-1:0]      out_r2,
  output logic [N-1:0]      out_r3,
  output logic              out_sat
);

  typedef enum logic [1:0] {IDLE, CALC_A, CALC_B, DONE} state_t;

  state_t              r_state, w_next;
  logic [N:0]          r_x1, r_y1;
  logic [N-1:0]        r_x2, r_x3, r_y3;
  logic [PASS_W-1:0]   r_cnt;
  logic                r_sat;

  logic [PASS_W-1:0]   w_p;
  logic                w_sat;
  logic [N:0]          w_y1, w_diff, w_t;
  logic [N-1:0]        w_y3, w_klo, w_y2;

  // (a - b) mod 2^(N+1)-1 with end-around carry; all-ones collapses to 0
  function automatic logic [N:0] sub_m1(input logic [N:0] a, input logic [N:0] b);
    logic [N+1:0] s;
    logic [N:0]   r;
    s = {1'b0, a} + {1'b0, ~b};
    r = s[N:0] + {{N{1'b0}}, s[N+1]};
    return (&r) ? '0 : r;
  endfunction

  // (a - b) mod 2^N-1 with end-around carry; all-ones collapses to 0
  function automatic logic [N-1:0] sub_m3(input logic [N-1:0] a, input logic [N-1:0] b);
    logic [N:0]   s;
    logic [N-1:0] r;
    s = {1'b0, a} + {1'b0, ~b};
    r = s[N-1:0] + {{(N-1){1'b0}}, s[N]};
    return (&r) ? '0 : r;
  endfunction

  // Pass-count clamp and saturation flag for the operand being offered
  always_comb begin
    w_sat = (in_passes > PASS_W'(MAX_PASSES));
    w_p   = w_sat ? PASS_W'(MAX_PASSES) : in_passes;
  end

  // Per-pass arithmetic. Multiplying by 2^-N is rotl1 mod m1 and identity mod m3.
  // CRT: Y = y3 + m3*k with k = (y1-y3)*m3^-1 mod m1, and m3^-1 = -2 mod m1, so
  // k is the ones-complement of rotl1(y1-y3); Y mod 2^N then reduces to y3 - k.
  always_comb begin
    w_y1   = '0;
    w_y3   = '0;
    w_diff = sub_m1(r_x1, {1'b0, r_x2});
    w_y1   = {w_diff[N-1:0], w_diff[N]};
    w_y3   = sub_m3(r_x3, r_x2);
    w_t    = sub_m1(r_y1, {1'b0, r_y3});
    w_t    = {w_t[N-1:0], w_t[N]};
    w_klo  = (w_t == '0) ? '0 : ~w_t[N-1:0];
    w_y2   = r_y3 - w_klo;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_next;
  end

  // Next-state and handshake outputs
  always_comb begin
    w_next    = r_state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (r_state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) w_next = (w_p == '0) ? DONE : CALC_A;
      end
      CALC_A: w_next = CALC_B;
      CALC_B: w_next = (r_cnt == PASS_W'(1)) ? DONE : CALC_A;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) w_next = IDLE;
      end
      default: w_next = IDLE;
    endcase
  end

  // Operand capture, working residues and pass counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_x1  <= '0;
      r_x2  <= '0;
      r_x3  <= '0;
      r_y1  <= '0;
      r_y3  <= '0;
      r_cnt <= '0;
      r_sat <= 1'b0;
    end else begin
      case (r_state)
        IDLE: if (in_valid) begin
          r_x1  <= (&in_r1) ? '0 : in_r1;
          r_x2  <= in_r2;
          r_x3  <= (&in_r3) ? '0 : in_r3;
          r_cnt <= w_p;
          r_sat <= w_sat;
        end
        CALC_A: begin
          r_y1 <= w_y1;
          r_y3 <= w_y3;
        end
        CALC_B: begin
          r_x1  <= r_y1;
          r_x2  <= w_y2;
          r_x3  <= r_y3;
          r_cnt <= r_cnt - PASS_W'(1);
        end
        default: ;
      endcase
    end
  end

  assign out_r1  = r_x1;
  assign out_r2  = r_x2;
  assign out_r3  = r_x3;
  assign out_sat = r_sat;

endmodule
